// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix-keypad scanner.
package keypad_pkg;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } key_state_e;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } frame_result_e;

    function automatic logic [2:0] count_keys(input logic [3:0] pressed);
        count_keys = {2'b00, pressed[0]} + {2'b00, pressed[1]}
                   + {2'b00, pressed[2]} + {2'b00, pressed[3]};
    endfunction

    // Lowest pressed column; only meaningful when exactly one bit is set.
    function automatic logic [1:0] first_col(input logic [3:0] pressed);
        if (pressed[0]) begin
            first_col = 2'd0;
        end else if (pressed[1]) begin
            first_col = 2'd1;
        end else if (pressed[2]) begin
            first_col = 2'd2;
        end else begin
            first_col = 2'd3;
        end
    endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad lines and key-event outputs; master is the scanner, slave the keypad/consumer side.
interface keypad_if;
    import keypad_pkg::*;

    logic [KEY_COLS-1:0] col_n;
    logic [KEY_ROWS-1:0] row_n;
    logic [3:0]          key_code;
    logic                key_valid;
    logic                key_held;

    modport master (input col_n, output row_n, key_code, key_valid, key_held);
    modport slave  (output col_n, input row_n, key_code, key_valid, key_held);

endinterface

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for the asynchronous active-low column lines; idles at all-ones.
module keypad_col_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] col_sync_n
);

    logic [3:0] meta_r;
    logic [3:0] sync_r;

    // Synchronizer chain
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 4'hF;
            sync_r <= 4'hF;
        end else begin
            meta_r <= col_n;
            sync_r <= meta_r;
        end
    end

    assign col_sync_n = sync_r;

endmodule

// File: rtl/keypad_scan_input.sv
// Row-scanning 4x4 keypad front end with frame-based debounce and one-cycle key_valid.
// Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_input
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 100
) (
    input  logic     clk,
    input  logic     reset,
    keypad_if.master kif
);

    localparam int                SLOT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [4:0]        DEB_TARGET = 5'(DEBOUNCE_SCANS);

`ifdef KEYPAD_REPEAT_EN
    localparam int               REP_W     = $clog2(2 * REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(2 * REPEAT_SCANS);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_SCANS);
    logic [REP_W-1:0] rep_r;
    logic [REP_W-1:0] rep_s;
    logic [REP_W-1:0] rep_inc_s;
`else
    localparam int UNUSED_REPEAT_SCANS = REPEAT_SCANS;
`endif

    logic [3:0]        col_sync_s;
    logic [SLOT_W-1:0] slot_cnt_r;
    logic [1:0]        row_idx_r;
    logic [3:0]        row_n_r;
    logic              sample_s;
    logic              eof_s;

    logic [3:0]        pressed_s;
    logic [2:0]        row_hits_s;
    logic [2:0]        hits_sum_s;
    logic [1:0]        hits_sat_s;
    logic [1:0]        hits_r;
    logic [3:0]        acc_code_r;
    logic [3:0]        frame_code_s;
    frame_result_e     result_s;

    key_state_e        state_r;
    key_state_e        state_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_s;
    logic [4:0]        cnt_inc_s;
    logic              cnt_done_s;
    logic [3:0]        cand_r;
    logic [3:0]        cand_s;
    logic [3:0]        key_code_r;
    logic [3:0]        code_s;
    logic              valid_s;
    logic              key_valid_r;
    logic              key_held_r;

    keypad_col_sync u_col_sync (
        .clk        (clk),
        .reset      (reset),
        .col_n      (kif.col_n),
        .col_sync_n (col_sync_s)
    );

    assign sample_s = (slot_cnt_r == SLOT_LAST);
    assign eof_s    = sample_s && (row_idx_r == 2'd3);

    // Slot timer and row drive
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_r <= {SLOT_W{1'b0}};
            row_idx_r  <= 2'd0;
            row_n_r    <= 4'b1110;
        end else if (sample_s) begin
            slot_cnt_r <= {SLOT_W{1'b0}};
            row_idx_r  <= row_idx_r + 2'd1;
            row_n_r    <= ~(4'b0001 << (row_idx_r + 2'd1));
        end else begin
            slot_cnt_r <= slot_cnt_r + {{(SLOT_W-1){1'b0}}, 1'b1};
        end
    end

    // Fold the current row's sample into the running frame tally (saturating at two keys)
    always_comb begin
        pressed_s    = ~col_sync_s;
        row_hits_s   = count_keys(pressed_s);
        hits_sum_s   = {1'b0, hits_r} + row_hits_s;
        hits_sat_s   = (hits_sum_s >= 3'd2) ? 2'd2 : hits_sum_s[1:0];
        frame_code_s = (row_hits_s == 3'd1) ? {row_idx_r, first_col(pressed_s)} : acc_code_r;
        case (hits_sat_s)
            2'd0:    result_s = NONE;
            2'd1:    result_s = SINGLE;
            default: result_s = MULTI;
        endcase
    end

    // Frame tally registers, cleared at each end of frame
    always_ff @(posedge clk) begin
        if (reset) begin
            hits_r     <= 2'd0;
            acc_code_r <= 4'd0;
        end else if (eof_s) begin
            hits_r     <= 2'd0;
            acc_code_r <= 4'd0;
        end else if (sample_s) begin
            hits_r     <= hits_sat_s;
            acc_code_r <= frame_code_s;
        end else begin
            hits_r     <= hits_r;
            acc_code_r <= acc_code_r;
        end
    end

    assign cnt_inc_s  = {1'b0, cnt_r} + 5'd1;
    assign cnt_done_s = (cnt_inc_s >= DEB_TARGET);

    // Debounce state machine, advanced once per frame
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        cand_s  = cand_r;
        code_s  = key_code_r;
        valid_s = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_s     = rep_r;
        rep_inc_s = rep_r + {{(REP_W-1){1'b0}}, 1'b1};
`endif
        if (eof_s) begin
            case (state_r)
                IDLE: begin
                    if (result_s == SINGLE) begin
                        cand_s = frame_code_s;
                        cnt_s  = 4'd1;
                        if (DEB_TARGET == 5'd1) begin
                            state_s = PRESSED;
                            code_s  = frame_code_s;
                            valid_s = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rep_s   = {REP_W{1'b0}};
`endif
                        end else begin
                            state_s = DEBOUNCE;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                DEBOUNCE: begin
                    if ((result_s == SINGLE) && (frame_code_s == cand_r)) begin
                        cnt_s = cnt_inc_s[3:0];
                        if (cnt_done_s) begin
                            state_s = PRESSED;
                            code_s  = cand_r;
                            valid_s = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rep_s   = {REP_W{1'b0}};
`endif
                        end else begin
                            state_s = DEBOUNCE;
                        end
                    end else if (result_s == SINGLE) begin
                        cand_s = frame_code_s;
                        cnt_s  = 4'd1;
                    end else begin
                        state_s = IDLE;
                        cnt_s   = 4'd0;
                    end
                end
                PRESSED: begin
                    if ((result_s == SINGLE) && (frame_code_s == key_code_r)) begin
                        state_s = PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        // Reload to REPEAT_SCANS so later pulses come every REPEAT_SCANS frames
                        if (rep_inc_s == REP_FIRST) begin
                            valid_s = 1'b1;
                            rep_s   = REP_RELOAD;
                        end else begin
                            rep_s   = rep_inc_s;
                        end
`endif
                    end else begin
                        state_s = RELEASE;
                        cnt_s   = 4'd1;
                    end
                end
                RELEASE: begin
                    if (result_s == NONE) begin
                        cnt_s = cnt_inc_s[3:0];
                        if (cnt_done_s) begin
                            state_s = IDLE;
                        end else begin
                            state_s = RELEASE;
                        end
                    end else if ((result_s == SINGLE) && (frame_code_s == key_code_r)) begin
                        state_s = PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        rep_s   = {REP_W{1'b0}};
`endif
                    end else begin
                        cnt_s = 4'd0;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = 4'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            cand_r      <= 4'd0;
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_r       <= {REP_W{1'b0}};
`endif
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            cand_r      <= cand_s;
            key_code_r  <= code_s;
            key_valid_r <= valid_s;
            key_held_r  <= (state_s == PRESSED) || (state_s == RELEASE);
`ifdef KEYPAD_REPEAT_EN
            rep_r       <= rep_s;
`endif
        end
    end

    assign kif.row_n     = row_n_r;
    assign kif.key_code  = key_code_r;
    assign kif.key_valid = key_valid_r;
    assign kif.key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scan_input.sv
// Self-checking bench for keypad_scan_input: directed scenarios then random frames against a frame-level model.
module tb_keypad_scan_input;

    localparam int SD = 4;
    localparam int DS = 3;
    localparam int RS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] keys;
    int          k;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Frame-level model of the accepted-key behaviour
    bit m_held, m_rel, m_pulse;
    int m_cand, m_code, m_run, m_rep;

    always #5 clk = ~clk;

    keypad_if kif ();

    keypad_scan_input #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DS),
        .REPEAT_SCANS   (RS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kif   (kif)
    );

    // Physical keypad: a pressed key pulls its column low while its row is driven
    always_comb begin
        kif.col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !kif.row_n[r]) kif.col_n[c] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at k=%0d", tag, obs, exp, k);
        end
    endtask

    // -1 = no key, -2 = two or more keys, else the key number (row*4+col)
    function automatic int frame_result(input logic [15:0] ks);
        int n, idx;
        n = 0; idx = 0;
        for (int i = 0; i < 16; i++) if (ks[i]) begin n++; idx = i; end
        if (n == 0) return -1;
        if (n == 1) return idx;
        return -2;
    endfunction

    task automatic model_clear();
        m_held = 1'b0; m_rel = 1'b0; m_pulse = 1'b0;
        m_cand = -1; m_code = 0; m_run = 0; m_rep = 0;
    endtask

    task automatic model_frame(input int fr);
        m_pulse = 1'b0;
        if (!m_held) begin
            if (fr >= 0 && fr == m_cand) m_run++;
            else if (fr >= 0) begin m_cand = fr; m_run = 1; end
            else m_cand = -1;
            if (m_cand >= 0 && m_run >= DS) begin
                m_held = 1'b1; m_rel = 1'b0; m_code = m_cand;
                m_cand = -1; m_pulse = 1'b1; m_rep = 0;
            end
        end else if (!m_rel) begin
            if (fr == m_code) begin
`ifdef KEYPAD_REPEAT_EN
                m_rep++;
                if (m_rep >= 2*RS && ((m_rep - 2*RS) % RS) == 0) m_pulse = 1'b1;
`endif
            end else begin
                m_rel = 1'b1; m_run = 1;
            end
        end else begin
            if (fr == -1) begin
                m_run++;
                if (m_run >= DS) begin m_held = 1'b0; m_rel = 1'b0; end
            end else if (fr == m_code) begin
                m_rel = 1'b0; m_rep = 0;
            end else m_run = 0;
        end
    endtask

    task automatic step_cycle();
        logic [3:0] exp_row;
        @(posedge clk); #1;
        k++;
        exp_row = ~(4'b0001 << ((k / SD) % 4));
        check("row_n", {4'h0, kif.row_n}, {4'h0, exp_row});
    endtask

    task automatic run_frame(input logic [15:0] ks);
        keys = ks;
        for (int i = 1; i <= 4*SD; i++) begin
            step_cycle();
            if (i == 4*SD) begin
                model_frame(frame_result(ks));
                check("key_valid_eof", {7'h0, kif.key_valid}, {7'h0, m_pulse});
                check("key_code_eof",  {4'h0, kif.key_code},  8'(m_code));
            end else begin
                check("key_valid_mid", {7'h0, kif.key_valid}, 8'h00);
            end
            check("key_held", {7'h0, kif.key_held}, {7'h0, m_held});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_row_n",     {4'h0, kif.row_n},    8'h0E);
        check("rst_key_code",  {4'h0, kif.key_code}, 8'h00);
        check("rst_key_valid", {7'h0, kif.key_valid}, 8'h00);
        check("rst_key_held",  {7'h0, kif.key_held},  8'h00);
        reset = 1'b0;
        keys  = 16'h0000;
        k     = 0;
        model_clear();
    endtask

    initial begin
        logic [15:0] ks;
        int u, a, b;
        reset = 1'b1;
        keys  = 16'h0000;
        k     = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        for (int f = 0; f < 4; f++) run_frame(16'h0000);          // idle scanning
        for (int f = 0; f < 5; f++) run_frame(16'h0200);          // key 9 held
        check("held_after_press", {7'h0, kif.key_held}, 8'h01);
        check("code_after_press", {4'h0, kif.key_code}, 8'h09);
        for (int f = 0; f < 4; f++) run_frame(16'h0000);          // release
        check("held_after_release", {7'h0, kif.key_held}, 8'h00);
        for (int f = 0; f < 3; f++) begin                          // bounce
            run_frame(16'h0200);
            run_frame(16'h0000);
        end
        for (int f = 0; f < 4; f++) run_frame(16'h0021);          // keys 0 and 5
        for (int f = 0; f < 12; f++) run_frame(16'h8000);         // key F held
        for (int i = 0; i < 6; i++) step_cycle();                  // into the next frame
        do_reset();                                                // reset mid-hold

        ks = 16'h0000;
        for (int f = 0; f < 80; f++) begin
            u = $urandom_range(0, 9);
            if (u >= 5 && u <= 6) ks = 16'h0000;
            else if (u >= 7 && u <= 8) ks = 16'd1 << $urandom_range(0, 15);
            else if (u == 9) begin
                a  = $urandom_range(0, 15);
                b  = (a + 1 + $urandom_range(0, 14)) % 16;
                ks = (16'd1 << a) | (16'd1 << b);
            end
            run_frame(ks);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
